// File: rtl/cnn_accel_pkg.sv
// Shared types and helpers for the CNN accelerator stages (conv2d, maxpool).
// Latency: n/a (types, constants, combinational helper).
// Backpressure: n/a.
// Contents: conv_state_t FSM encoding, bus direction constants and clamp_out.
// clamp_out clamps with ReLU semantics when the CONV_RELU_EN macro is defined.
// Otherwise it saturates to the signed range.
package cnn_accel_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_INPUT,
    LOAD_KERNEL,
    INIT_WINDOW,
    MAC,
    QUANT,
    WRITE_OUTPUT,
    NEXT,
    FINISHED
  } conv_state_t;

  // mem_w encoding on the shared bus
  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  // Clamp a sign-extended value to dw bits; result is returned zero-extended.
  function automatic logic [31:0] clamp_out(input logic signed [31:0] s, input int dw);
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    logic signed [31:0] r;
`ifdef CONV_RELU_EN
    lo = 32'sd0;
    hi = (32'sd1 <<< dw) - 32'sd1;
`else
    lo = -(32'sd1 <<< (dw - 1));
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
`endif
    if (s < lo)      r = lo;
    else if (s > hi) r = hi;
    else             r = s;
    return r & ((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: acc += a*b, with the product sign-extended to ACC_WIDTH.
// Latency: 1 cycle per accumulate; the result is visible the cycle after en.
// Backpressure: none; the caller gates en.
// Ports: clk, rst (sync active-low), clr (zero acc), en (accumulate), a/b (signed operands), acc.
module conv_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_WIDTH'(prod);
  end

endmodule

// File: rtl/conv2d_relu_with_mem.sv
// KxK stride-1 convolution with clamping; reads its tile and kernel and writes results over a shared memory bus.
// Latency: 3 cycles per word loaded, then 15 cycles per output pixel at K=3 (zero-wait memory).
// Backpressure: each bus request is held unchanged until ready; one idle stall cycle follows every transfer.
// Ports: clk, rst (sync active-low), start/done handshake, input/kernel/output base addresses,
//        mem_sel/mem_w request, tri-stated address_bus/data_bus, ready completion strobe.
// Config: define CONV_RELU_EN for ReLU clamping [0, 2^DW-1]; the default is signed saturation.
module conv2d_relu_with_mem
  import cnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int HEIGHT        = 6,
  parameter int WIDTH         = 6,
  parameter int K             = 3,
  parameter int ACC_WIDTH     = 20,
  parameter int OUT_SHIFT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [ADDR_WIDTH-1:0] kernel_addr,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  output logic                  mem_w,
  output logic                  mem_sel,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                  ready
);

  localparam int OUT_H = HEIGHT - K + 1;
  localparam int OUT_W = WIDTH - K + 1;
  localparam int N_IN  = HEIGHT * WIDTH;
  localparam int N_K   = K * K;
  localparam int CW    = $clog2(N_IN + 1);
  localparam int IIW   = $clog2(N_IN);
  localparam int KIW   = $clog2(N_K);

  conv_state_t state;
  logic [ADDR_WIDTH-1:0]    k_base, out_base, address;
  logic [DATABUS_WIDTH-1:0] data;
  logic                     stall;
  logic [CW-1:0]            idx, x, y, ki, kj;

  logic signed [DATA_WIDTH-1:0] in_mem [N_IN];
  logic signed [DATA_WIDTH-1:0] k_mem  [N_K];
  logic [IIW-1:0]               in_rd;
  logic [KIW-1:0]               k_rd;
  logic signed [DATA_WIDTH-1:0] mac_a, mac_b;
  logic signed [ACC_WIDTH-1:0]  acc, shifted;
  logic                         in_we, k_we;

  assign address_bus = mem_sel ? address : 'z;
  assign data_bus    = (mem_sel && mem_w) ? data : 'z;

  // Only the low DATA_WIDTH bits of a read carry data.
  wire unused_bus_bits = &{1'b0, data_bus[DATABUS_WIDTH-1:DATA_WIDTH]};

  // A load word is captured on the ready edge of a live request; stall cycles ignore ready.
  assign in_we = (state == LOAD_INPUT)  && !stall && ready;
  assign k_we  = (state == LOAD_KERNEL) && !stall && ready;

  always_ff @(posedge clk) begin
    if (in_we) in_mem[IIW'(idx)] <= data_bus[DATA_WIDTH-1:0];
    if (k_we)  k_mem[KIW'(idx)]  <= data_bus[DATA_WIDTH-1:0];
  end

  always_comb begin
    in_rd = IIW'((int'(y) + int'(ki)) * WIDTH + int'(x) + int'(kj));
    k_rd  = KIW'(int'(ki) * K + int'(kj));
  end

  assign mac_a   = in_mem[in_rd];
  assign mac_b   = k_mem[k_rd];
  assign shifted = acc >>> OUT_SHIFT;

  conv_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state == INIT_WINDOW),
    .en (state == MAC),
    .a  (mac_a),
    .b  (mac_b),
    .acc(acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      mem_w    <= BUS_RD;
      mem_sel  <= 1'b0;
      address  <= '0;
      data     <= '0;
      stall    <= 1'b0;
      k_base   <= '0;
      out_base <= '0;
      idx      <= '0;
      x        <= '0;
      y        <= '0;
      ki       <= '0;
      kj       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // The input base goes straight into the address register so the first read issues immediately.
            address  <= input_addr;
            k_base   <= kernel_addr;
            out_base <= output_addr;
            idx      <= '0;
            x        <= '0;
            y        <= '0;
            stall    <= 1'b0;
            mem_w    <= BUS_RD;
            mem_sel  <= 1'b1;
            state    <= LOAD_INPUT;
          end
        end
        LOAD_INPUT: begin
          if (stall) begin
            stall   <= 1'b0;
            mem_sel <= 1'b1;
            if (idx == CW'(N_IN - 1)) begin
              idx     <= '0;
              address <= k_base;
              state   <= LOAD_KERNEL;
            end else begin
              idx     <= idx + 1'b1;
              address <= address + 1'b1;
            end
          end else if (ready) begin
            mem_sel <= 1'b0;
            stall   <= 1'b1;
          end
        end
        LOAD_KERNEL: begin
          if (stall) begin
            stall <= 1'b0;
            if (idx == CW'(N_K - 1)) begin
              idx   <= '0;
              state <= INIT_WINDOW;
            end else begin
              idx     <= idx + 1'b1;
              address <= address + 1'b1;
              mem_sel <= 1'b1;
            end
          end else if (ready) begin
            mem_sel <= 1'b0;
            stall   <= 1'b1;
          end
        end
        INIT_WINDOW: begin
          ki    <= '0;
          kj    <= '0;
          state <= MAC;
        end
        MAC: begin
          if (kj == CW'(K - 1)) begin
            kj <= '0;
            if (ki == CW'(K - 1)) state <= QUANT;
            else                  ki    <= ki + 1'b1;
          end else begin
            kj <= kj + 1'b1;
          end
        end
        QUANT: begin
          // acc holds the full window sum here; the write request issues together with the data.
          data    <= DATABUS_WIDTH'(clamp_out(32'(shifted), DATA_WIDTH));
          address <= out_base + ADDR_WIDTH'(int'(y) * OUT_W + int'(x));
          mem_w   <= BUS_WR;
          mem_sel <= 1'b1;
          state   <= WRITE_OUTPUT;
        end
        WRITE_OUTPUT: begin
          if (stall) begin
            stall <= 1'b0;
            state <= NEXT;
          end else if (ready) begin
            mem_sel <= 1'b0;
            mem_w   <= BUS_RD;
            stall   <= 1'b1;
          end
        end
        NEXT: begin
          if (x == CW'(OUT_W - 1)) begin
            x <= '0;
            if (y == CW'(OUT_H - 1)) begin
              done  <= 1'b1;
              state <= FINISHED;
            end else begin
              y     <= y + 1'b1;
              state <= INIT_WINDOW;
            end
          end else begin
            x     <= x + 1'b1;
            state <= INIT_WINDOW;
          end
        end
        FINISHED: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_relu_with_mem.sv
`timescale 1ns/1ps
module tb_conv2d_relu_with_mem;

  localparam int DW = 8, AW = 8, BW = 32, H = 6, W = 6, K = 3, ACCW = 20, SH = 0;
  localparam int OH = H - K + 1, OW = W - K + 1;
  localparam int N_RD = H * W + K * K;
  localparam logic [7:0] IN_BASE = 8'h10, K_BASE = 8'h40, OUT_BASE = 8'h80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic done, mem_w, mem_sel;
  logic [AW-1:0] input_addr  = IN_BASE;
  logic [AW-1:0] kernel_addr = K_BASE;
  logic [AW-1:0] output_addr = OUT_BASE;
  wire  [AW-1:0] address_bus;
  wire  [BW-1:0] data_bus;

  logic [7:0]  mem [256];
  logic [7:0]  exp_rd [$];
  logic [15:0] exp_wr [$];
  int n_chk = 0, n_pass = 0;
  int wait_n = 0, rcnt = 0, wr_seen = 0, gap = 0;

  // Memory drives read data only while the block requests a read.
  assign data_bus = (mem_sel === 1'b1 && mem_w === 1'b0) ? {24'h0, mem[address_bus]} : {BW{1'bz}};

  conv2d_relu_with_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATABUS_WIDTH(BW), .HEIGHT(H), .WIDTH(W),
    .K(K), .ACC_WIDTH(ACCW), .OUT_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .input_addr(input_addr), .kernel_addr(kernel_addr), .output_addr(output_addr),
    .mem_w(mem_w), .mem_sel(mem_sel), .address_bus(address_bus), .data_bus(data_bus),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory responder: ready comes wait_n cycles after the minimum 2-cycle request.
  initial forever begin
    @(negedge clk);
    if (ready) begin
      ready = 1'b0;
      rcnt  = 0;
    end else if (mem_sel === 1'b1) begin
      rcnt++;
      if (rcnt >= wait_n + 2) begin
        ready = 1'b1;
        if (mem_w === 1'b1) mem[address_bus] = data_bus[7:0];
      end
    end else begin
      rcnt = 0;
    end
  end

  // Bus protocol and scoreboard compare, sampled just after every rising edge.
  logic        prev_sel = 1'b0, prev_w = 1'b0;
  logic [7:0]  prev_addr = 8'h0;
  logic [31:0] prev_dat = 32'h0;
  logic [15:0] mon_e;
  bit          mon_en = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (prev_sel && ready) begin
        chk("stall_after_ready", {31'h0, mem_sel}, 32'h0);
        gap = 1;
        if (prev_w) begin
          chk("write_expected", 32'(exp_wr.size() > 0), 32'h1);
          if (exp_wr.size() > 0) begin
            mon_e = exp_wr.pop_front();
            chk("write_addr", {24'h0, prev_addr}, {24'h0, mon_e[15:8]});
            chk("write_data", prev_dat, {24'h0, mon_e[7:0]});
            wr_seen++;
          end
        end else begin
          chk("read_expected", 32'(exp_rd.size() > 0), 32'h1);
          if (exp_rd.size() > 0) chk("read_addr", {24'h0, prev_addr}, {24'h0, exp_rd.pop_front()});
        end
      end else if (prev_sel) begin
        chk("hold_sel", {31'h0, mem_sel}, 32'h1);
        chk("hold_addr", {24'h0, address_bus}, {24'h0, prev_addr});
        chk("hold_w", {31'h0, mem_w}, {31'h0, prev_w});
        if (prev_w) chk("hold_data", data_bus, prev_dat);
      end else if (mem_sel === 1'b1) begin
        if (mem_w === 1'b0 && exp_rd.size() < N_RD) chk("one_stall_gap", gap, 1);
        gap = 0;
      end else begin
        gap++;
      end
      if (mem_sel !== 1'b1) begin
        chk("addr_released", {31'h0, address_bus === {AW{1'bz}}}, 32'h1);
        chk("data_released", {31'h0, data_bus === {BW{1'bz}}}, 32'h1);
      end
    end
    prev_sel  = (mem_sel === 1'b1);
    prev_w    = (mem_w === 1'b1);
    prev_addr = address_bus;
    prev_dat  = data_bus;
  end

  // kind 0: ramp input + identity kernel; 1: all 100 + all-ones kernel; 2: all 5 + centre -1.
  task automatic load_pattern(input int kind);
    for (int i = 0; i < H * W; i++)
      mem[IN_BASE + i] = (kind == 0) ? 8'(i) : ((kind == 1) ? 8'd100 : 8'd5);
    for (int i = 0; i < K * K; i++)
      mem[K_BASE + i] = (kind == 1) ? 8'd1 :
                        ((i == (K * K) / 2) ? ((kind == 0) ? 8'd1 : 8'hFF) : 8'd0);
  endtask

  // Reference: direct 2-D convolution over the memory image, then shift and clamp.
  task automatic build_exp();
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < H * W; i++) exp_rd.push_back(8'(IN_BASE + i));
    for (int i = 0; i < K * K; i++) exp_rd.push_back(8'(K_BASE + i));
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        int acc, s, r, pv, kv;
        acc = 0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            pv = $signed(mem[IN_BASE + (y + i) * W + x + j]);
            kv = $signed(mem[K_BASE + i * K + j]);
            acc += pv * kv;
          end
        end
        s = acc >>> SH;
`ifdef CONV_RELU_EN
        r = (s < 0) ? 0 : ((s > 2**DW - 1) ? 2**DW - 1 : s);
`else
        r = (s < -(2**(DW-1))) ? -(2**(DW-1)) : ((s > 2**(DW-1) - 1) ? 2**(DW-1) - 1 : s);
`endif
        exp_wr.push_back({8'(OUT_BASE + y * OW + x), 8'(r)});
      end
    end
  endtask

  task automatic run_conv(input int wn, input string tag);
    int cyc;
    wait_n = wn;
    for (int i = 0; i < OH * OW; i++) mem[OUT_BASE + i] = 8'h00;
    build_exp();
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_latency"}, cyc, 45 * (3 + wn) + 16 * (15 + wn) + 1);
    chk({tag, "_writes_left"}, exp_wr.size(), 0);
    chk({tag, "_reads_left"}, exp_rd.size(), 0);
    // start held high after completion: done stays up, bus stays quiet
    repeat (4) begin
      @(negedge clk);
      chk({tag, "_done_hold"}, {31'h0, done}, 32'h1);
      chk({tag, "_quiet_bus"}, {31'h0, mem_sel}, 32'h0);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clear"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_mem_sel", {31'h0, mem_sel}, 32'h0);
    chk("reset_mem_w", {31'h0, mem_w}, 32'h0);
    chk("reset_addr_z", {31'h0, address_bus === {AW{1'bz}}}, 32'h1);
    chk("reset_data_z", {31'h0, data_bus === {BW{1'bz}}}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    load_pattern(0);
    run_conv(0, "identity");
    chk("identity_px0", {24'h0, mem[OUT_BASE + 0]}, 32'd7);
    chk("identity_px5", {24'h0, mem[OUT_BASE + 5]}, 32'd14);
    chk("identity_px15", {24'h0, mem[OUT_BASE + 15]}, 32'd28);

    load_pattern(1);
    run_conv(0, "saturate");
`ifdef CONV_RELU_EN
    chk("saturate_px3", {24'h0, mem[OUT_BASE + 3]}, 32'hFF);
`else
    chk("saturate_px3", {24'h0, mem[OUT_BASE + 3]}, 32'h7F);
`endif

    load_pattern(2);
    run_conv(0, "negative");
`ifdef CONV_RELU_EN
    chk("negative_px9", {24'h0, mem[OUT_BASE + 9]}, 32'h00);
`else
    chk("negative_px9", {24'h0, mem[OUT_BASE + 9]}, 32'hFB);
`endif

    load_pattern(0);
    run_conv(3, "waitstates");
    chk("waitstates_px6", {24'h0, mem[OUT_BASE + 6]}, 32'd15);

    // Reset pulse during the MAC of pixel 5
    load_pattern(0);
    wait_n = 0;
    for (int i = 0; i < OH * OW; i++) mem[OUT_BASE + i] = 8'h00;
    build_exp();
    wr_seen = 0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (wr_seen < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_reached_px5", wr_seen, 5);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_mem_sel", {31'h0, mem_sel}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_addr_z", {31'h0, address_bus === {AW{1'bz}}}, 32'h1);
    chk("midrst_data_z", {31'h0, data_bus === {BW{1'bz}}}, 32'h1);
    repeat (20) @(negedge clk);
    chk("midrst_no_more_writes", wr_seen, 5);
    chk("midrst_px6_untouched", {24'h0, mem[OUT_BASE + 6]}, 32'h0);
    exp_wr.delete();
    exp_rd.delete();

    load_pattern(0);
    run_conv(0, "rerun");
    chk("rerun_px12", {24'h0, mem[OUT_BASE + 12]}, 32'd25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
